// File: rtl/phy_pkg.sv
// phy_pkg - constants and types shared by the serial transmit and receive paths.
// Holds the comma word, the link state type and the default sync length.
package phy_pkg;

  localparam logic [7:0] COMMA = 8'hBC;

  localparam int NUM_SYNC_DEF = 4;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_t;

endpackage

// File: rtl/phy_serial_tx.sv
// phy_serial_tx - MSB-first word serialiser with comma sync preamble.
// Define TX_WORD_CNT_EN to add the 16-bit word_cnt output.
module phy_serial_tx
  import phy_pkg::*;
#(
  parameter int NUM_SYNC = NUM_SYNC_DEF
) (
  input  logic        clk8f,
  input  logic        reset,
  input  logic [7:0]  data_in,
  input  logic        empty,
  output logic        rd_en,
  output logic        data_out,
  output logic        active
`ifdef TX_WORD_CNT_EN
  ,
  output logic [15:0] word_cnt
`endif
);

  localparam logic [3:0] LAST_SYNC = 4'(NUM_SYNC - 1);

  logic [7:0] r_shift;
  logic [2:0] r_bitcnt;
  logic [3:0] r_synccnt;
  tx_state_t  r_state;
  logic       r_active;

  logic       w_boundary;
  logic       w_last_sync;
  logic       w_rd_en;
  logic [7:0] w_next;

  assign w_boundary  = (r_bitcnt == 3'd7);
  assign w_last_sync = (r_synccnt == LAST_SYNC);

  // The final sync boundary may already carry the first data word.
  assign w_rd_en = w_boundary && !empty &&
                   ((r_state == ACTIVE) || w_last_sync);

  assign w_next = w_rd_en ? data_in : COMMA;

  assign rd_en    = w_rd_en;
  assign data_out = r_shift[7];
  assign active   = r_active;

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      r_shift   <= COMMA;
      r_bitcnt  <= 3'd0;
      r_synccnt <= 4'd0;
      r_state   <= SYNC;
      r_active  <= 1'b0;
    end else if (w_boundary) begin
      r_bitcnt <= 3'd0;
      r_shift  <= w_next;
      if (r_state == SYNC) begin
        r_synccnt <= r_synccnt + 4'd1;
        if (w_last_sync) begin
          r_state  <= ACTIVE;
          r_active <= 1'b1;
        end
      end
    end else begin
      r_bitcnt <= r_bitcnt + 3'd1;
      r_shift  <= {r_shift[6:0], 1'b0};
    end
  end

`ifdef TX_WORD_CNT_EN
  logic [15:0] r_wcnt;

  always_ff @(posedge clk8f or posedge reset) begin
    if (reset) begin
      r_wcnt <= 16'd0;
    end else if (w_rd_en) begin
      r_wcnt <= r_wcnt + 16'd1;
    end
  end

  assign word_cnt = r_wcnt;
`endif

endmodule
